// File: rtl/seq_scan_ctrl_if.sv
// Word-in / result-out stream bundle for seq_scan_ctrl.
// master = producer/consumer side, slave = the controller.
interface seq_scan_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [CNT_W-1:0] out_count;
  logic             out_sat;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_count, out_sat, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_count, out_sat, out_valid
  );
endinterface

// File: rtl/seq_scan_ctrl.sv
// Serializes a word LSB-first into an external 110 detector and counts its hits.
// Define SEQ_SCAN_CONTINUE_EN to carry detector state across word boundaries.
module seq_scan_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  seq_scan_ctrl_if.slave     bus,
  output logic               det_a,
  output logic               det_reset,
  input  logic               det_w
);
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
`ifdef SEQ_SCAN_CONTINUE_EN
  localparam bit CONTINUE = 1'b1;
`else
  localparam bit CONTINUE = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, CLR, SHIFT, DRAIN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] word;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] cnt;
  logic             sat;
  logic             primed;
  logic             det_clr;
  logic             rdy;
  logic             vld;
  logic             inc;

  // det_w at SHIFT idx 0 still reflects the detector before this word's first bit
  always_comb begin
    inc = det_w && ((state == SHIFT && idx != '0) || state == DRAIN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      word    <= '0;
      idx     <= '0;
      cnt     <= '0;
      sat     <= 1'b0;
      primed  <= 1'b0;
      det_clr <= 1'b0;
      det_a   <= 1'b0;
      rdy     <= 1'b1;
      vld     <= 1'b0;
    end else begin
      det_clr <= 1'b0;
      det_a   <= 1'b0;
      if (inc) begin
        if (cnt == CNT_MAX) sat <= 1'b1;
        else                cnt <= cnt + 1'b1;
      end
      case (state)
        IDLE: if (bus.in_valid) begin
          word <= bus.in_data;
          cnt  <= '0;
          sat  <= 1'b0;
          idx  <= '0;
          rdy  <= 1'b0;
          if (primed) begin
            state <= SHIFT;
            det_a <= bus.in_data[0];
          end else begin
            state   <= CLR;
            det_clr <= 1'b1;
          end
        end
        CLR: begin
          state  <= SHIFT;
          det_a  <= word[0];
          primed <= CONTINUE;
        end
        // word shifts right so the next serial bit is always word[1]
        SHIFT: begin
          if (idx == LAST) begin
            state <= DRAIN;
          end else begin
            idx   <= idx + 1'b1;
            det_a <= word[1];
            word  <= word >> 1;
          end
        end
        DRAIN: begin
          state <= DONE;
          vld   <= 1'b1;
        end
        DONE: if (bus.out_ready) begin
          state <= IDLE;
          vld   <= 1'b0;
          rdy   <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // reset reaches the detector on the same edge that resets this controller
  assign det_reset     = det_clr | reset;
  assign bus.in_ready  = rdy;
  assign bus.out_valid = vld;
  assign bus.out_count = cnt;
  assign bus.out_sat   = sat;
endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Directed bench: two controllers (CNT_W=4 and CNT_W=1) in lockstep, each with
// a behavioural 110 Moore detector that only advances while a serial bit is live.
module tb_seq_scan_ctrl;
`ifdef SEQ_SCAN_CONTINUE_EN
  localparam bit CONT = 1'b1;
`else
  localparam bit CONT = 1'b0;
`endif
  localparam int WIDTH = 8;

  logic clk, reset, det_en;
  logic det_a0, det_reset0, det_w0, det_a1, det_reset1, det_w1;
  logic [1:0] dst0, dst1;
  int n_cmp = 0, n_bad = 0;
  bit exp_primed = 1'b0;

  seq_scan_ctrl_if #(.WIDTH(WIDTH), .CNT_W(4)) bus0();
  seq_scan_ctrl_if #(.WIDTH(WIDTH), .CNT_W(1)) bus1();

  assign bus1.in_data   = bus0.in_data;
  assign bus1.in_valid  = bus0.in_valid;
  assign bus1.out_ready = bus0.out_ready;

  seq_scan_ctrl #(.WIDTH(WIDTH), .CNT_W(4)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0.slave),
    .det_a(det_a0), .det_reset(det_reset0), .det_w(det_w0));
  seq_scan_ctrl #(.WIDTH(WIDTH), .CNT_W(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1.slave),
    .det_a(det_a1), .det_reset(det_reset1), .det_w(det_w1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 0:S0 1:S1 2:S11 3:S110
  function automatic logic [1:0] nxt(input logic [1:0] s, input logic a);
    if (a) return (s == 2'd1 || s == 2'd2) ? 2'd2 : 2'd1;
    else   return (s == 2'd2) ? 2'd3 : 2'd0;
  endfunction

  always @(posedge clk) begin
    if (det_reset0) dst0 <= 2'd0; else if (det_en) dst0 <= nxt(dst0, det_a0);
    if (det_reset1) dst1 <= 2'd0; else if (det_en) dst1 <= nxt(dst1, det_a1);
  end
  assign det_w0 = (dst0 == 2'd3);
  assign det_w1 = (dst1 == 2'd3);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic run_word(input logic [7:0] d, input int exp_cnt, input int hold, input string tag);
    int clr, lat, c;
    bit got;
    clr = exp_primed ? 0 : 1;
    lat = WIDTH + 1 + clr;
    @(negedge clk);
    chk({tag, "_rdy_idle"}, bus0.in_ready, 1);
    bus0.in_data  = d;
    bus0.in_valid = 1'b1;
    bus0.out_ready = 1'b0;
    @(posedge clk);
    c = 0; got = 1'b0;
    while (!got && c < lat + 6) begin
      @(negedge clk);
      c++;
      if (c == 1) begin
        chk({tag, "_rdy_busy"}, bus0.in_ready, 0);
        chk({tag, "_det_reset"}, det_reset0, clr);
        bus0.in_valid = 1'b0;
      end
      if (bus0.out_valid) got = 1'b1;
      det_en = (c >= 1 + clr && c <= WIDTH + clr);
    end
    det_en = 1'b0;
    chk({tag, "_latency"}, c, lat + 1);
    chk({tag, "_count"}, bus0.out_count, exp_cnt);
    chk({tag, "_sat"}, bus0.out_sat, 0);
    chk({tag, "_vld1"}, bus1.out_valid, 1);
    chk({tag, "_count1"}, bus1.out_count, (exp_cnt > 1) ? 1 : exp_cnt);
    chk({tag, "_sat1"}, bus1.out_sat, (exp_cnt > 1) ? 1 : 0);
    if (CONT) exp_primed = 1'b1;
    for (int i = 0; i < hold; i++) begin
      bus0.in_valid = 1'b1;
      bus0.in_data  = ~d;
      @(negedge clk);
      chk({tag, "_hold_vld"}, bus0.out_valid, 1);
      chk({tag, "_hold_cnt"}, bus0.out_count, exp_cnt);
      chk({tag, "_hold_rdy"}, bus0.in_ready, 0);
    end
    bus0.in_valid  = 1'b0;
    bus0.out_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_rel_vld"}, bus0.out_valid, 0);
    chk({tag, "_rel_rdy"}, bus0.in_ready, 1);
    bus0.out_ready = 1'b0;
  endtask

  task automatic reset_mid_shift();
    int clr;
    clr = exp_primed ? 0 : 1;
    @(negedge clk);
    bus0.in_data  = 8'b00110110;
    bus0.in_valid = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 1 + clr + 3; c++) begin
      @(negedge clk);
      bus0.in_valid = 1'b0;
      det_en = (c >= 1 + clr);
    end
    reset = 1'b1;
    #1;
    chk("rst_mid_det_reset", det_reset0, 1);
    @(negedge clk);
    reset  = 1'b0;
    det_en = 1'b0;
    chk("rst_mid_rdy", bus0.in_ready, 1);
    chk("rst_mid_vld", bus0.out_valid, 0);
    chk("rst_mid_det_a", det_a0, 0);
    chk("rst_mid_cnt", bus0.out_count, 0);
    exp_primed = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    det_en = 1'b0;
    bus0.in_data = '0;
    bus0.in_valid = 1'b0;
    bus0.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_det_reset", det_reset0, 1);
    reset = 1'b0;
    chk("rst_rdy", bus0.in_ready, 1);
    chk("rst_vld", bus0.out_valid, 0);
    chk("rst_cnt", bus0.out_count, 0);
    chk("rst_sat", bus0.out_sat, 0);
    chk("rst_det_a", det_a0, 0);

    run_word(8'b00110110, 2, 0, "w36");
    run_word(8'hFF, 0, 5, "wff");
    run_word(8'h00, CONT ? 1 : 0, 0, "w00");
    reset_mid_shift();
    run_word(8'b00110110, 2, 0, "post_rst");
    run_word(8'h6D, 2, 0, "w6d");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
